nubus_vram_bridge: RTL

- Sits directly downstream of the NuBus video card's VRAM port and adapts it to one client port of the shared SDRAM controller.
- Card side: level request (vram_rd/vram_wr held until a one-cycle vram_ready). SDRAM side: req/ack command handshake plus a separate read-data-valid strobe.
- Adds base-address relocation, a per-transaction timeout with error flag, and an optional one-word read-ahead buffer for linear scanout.

---
 rtl/nubus_vram_bridge.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/nubus_vram_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nubus_vram_bridge: NuBus VRAM port to SDRAM client port bridge with        |
// | relocation, per-transaction timeout and optional read-ahead buffer         |
// | (enabled by defining NUBUS_VRAM_PREFETCH_EN).                              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nubus_vram_bridge #(
  parameter logic [24:0] VRAM_BASE = 25'h1C00000,
  parameter int          TIMEOUT   = 255,
  parameter int          CNT_W     = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [24:0] vram_addr,
  input  logic [15:0] vram_dout,
  input  logic        vram_rd,
  input  logic        vram_wr,
  output logic [15:0] vram_din,
  output logic        vram_ready,
  output logic        sd_req,
  output logic        sd_we,
  output logic [24:0] sd_addr,
  output logic [15:0] sd_wdata,
  input  logic        sd_ack,
  input  logic        sd_rvalid,
  input  logic [15:0] sd_rdata,
  input  logic        err_clr,
  output logic        err_sticky
);

  localparam logic [2:0] c_idle      = 3'd0;
  localparam logic [2:0] c_issue     = 3'd1;
  localparam logic [2:0] c_wait_data = 3'd2;
  localparam logic [2:0] c_done      = 3'd3;
  localparam logic [2:0] c_release   = 3'd4;
`ifdef NUBUS_VRAM_PREFETCH_EN
  localparam logic [2:0] c_pf_issue  = 3'd5;
  localparam logic [2:0] c_pf_wait   = 3'd6;
`endif

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_vram_din;
  logic             r_sd_req;
  logic             r_sd_we;
  logic [24:0]      r_sd_addr;
  logic [15:0]      r_sd_wdata;
  logic             r_err;
  logic             w_timeout;
  logic             w_err_set;
  logic [24:0]      w_card_addr;

`ifdef NUBUS_VRAM_PREFETCH_EN
  logic [24:0] r_pf_addr;
  logic [15:0] r_pf_data;
  logic        r_pf_valid;
  logic        r_pf_pend;
  logic [24:0] w_pf_sd_addr;
  logic        w_pf_hit;

  assign w_pf_sd_addr = VRAM_BASE + r_pf_addr;
  assign w_pf_hit     = r_pf_valid && (r_pf_addr == vram_addr);
`endif

  // Relocation wraps modulo 2^25 by construction of the 25-bit sum.
  assign w_card_addr = VRAM_BASE + vram_addr;
  assign w_timeout   = (r_cnt == c_cnt_last);
  assign w_err_set   = w_timeout &&
                       (((r_state == c_issue) && !sd_ack) ||
                        ((r_state == c_wait_data) && !sd_rvalid));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_idle;
      r_cnt      <= '0;
      r_vram_din <= '0;
      r_sd_req   <= 1'b0;
      r_sd_we    <= 1'b0;
      r_sd_addr  <= '0;
      r_sd_wdata <= '0;
`ifdef NUBUS_VRAM_PREFETCH_EN
      r_pf_addr  <= '0;
      r_pf_data  <= '0;
      r_pf_valid <= 1'b0;
      r_pf_pend  <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_idle: begin
`ifdef NUBUS_VRAM_PREFETCH_EN
          if (vram_wr) begin
            r_pf_valid <= 1'b0;
            r_pf_pend  <= 1'b0;
          end else if (vram_rd) begin
            r_pf_valid <= 1'b0;
            r_pf_pend  <= 1'b1;
            r_pf_addr  <= vram_addr + 25'd1;
          end
          if (!vram_wr && vram_rd && w_pf_hit) begin
            r_vram_din <= r_pf_data;
            r_state    <= c_done;
          end else if (vram_wr || vram_rd) begin
            r_sd_req   <= 1'b1;
            r_sd_we    <= vram_wr;
            r_sd_addr  <= w_card_addr;
            r_sd_wdata <= vram_dout;
            r_cnt      <= '0;
            r_state    <= c_issue;
          end else if (r_pf_pend) begin
            r_pf_pend  <= 1'b0;
            r_sd_req   <= 1'b1;
            r_sd_we    <= 1'b0;
            r_sd_addr  <= w_pf_sd_addr;
            r_cnt      <= '0;
            r_state    <= c_pf_issue;
          end
`else
          // Write wins when both requests are raised together.
          if (vram_wr || vram_rd) begin
            r_sd_req   <= 1'b1;
            r_sd_we    <= vram_wr;
            r_sd_addr  <= w_card_addr;
            r_sd_wdata <= vram_dout;
            r_cnt      <= '0;
            r_state    <= c_issue;
          end
`endif
        end
        c_issue: begin
          if (sd_ack) begin
            r_sd_req <= 1'b0;
            r_state  <= r_sd_we ? c_done : c_wait_data;
            r_cnt    <= r_cnt + 1'b1;
          end else if (w_timeout) begin
            r_sd_req <= 1'b0;
            if (!r_sd_we) r_vram_din <= 16'hFFFF;
            r_state  <= c_done;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        c_wait_data: begin
          if (sd_rvalid) begin
            r_vram_din <= sd_rdata;
            r_state    <= c_done;
          end else if (w_timeout) begin
            r_vram_din <= 16'hFFFF;
            r_state    <= c_done;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        c_done: r_state <= c_release;
        // Hold here so a request still asserted after completion is not re-issued.
        c_release: begin
          if (!vram_rd && !vram_wr) r_state <= c_idle;
        end
`ifdef NUBUS_VRAM_PREFETCH_EN
        c_pf_issue: begin
          if (sd_ack) begin
            r_sd_req <= 1'b0;
            r_state  <= c_pf_wait;
            r_cnt    <= r_cnt + 1'b1;
          end else if (w_timeout) begin
            r_sd_req <= 1'b0;
            r_state  <= c_idle;
          end else begin
            r_cnt    <= r_cnt + 1'b1;
          end
        end
        c_pf_wait: begin
          if (sd_rvalid) begin
            r_pf_data  <= sd_rdata;
            r_pf_valid <= 1'b1;
            r_state    <= c_idle;
          end else if (w_timeout) begin
            r_state    <= c_idle;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
          end
        end
`endif
        default: r_state <= c_idle;
      endcase
    end
  end

  // A timeout in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= w_err_set || (r_err && !err_clr);
  end

  assign vram_ready = (r_state == c_done);
  assign vram_din   = r_vram_din;
  assign sd_req     = r_sd_req;
  assign sd_we      = r_sd_we;
  assign sd_addr    = r_sd_addr;
  assign sd_wdata   = r_sd_wdata;
  assign err_sticky = r_err;

endmodule
`default_nettype wire
